// File: rtl/arith_pipe.sv
// RV32I integer ALU with a fixed-latency, bubble-collapsing result pipeline.
// The result is computed at issue and sits in stage 1. Stages 2..STAGES only
// delay it. Each stage moves forward whenever the stage ahead of it has room.
module arith_pipe #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             arith_request_i,
  output logic             arith_ready_o,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      rs1_value_i,
  input  logic [31:0]      rs2_value_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      writeback_value_o,
  output logic [4:0]       wb_rd_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             wb_illegal_o
);

  localparam logic [6:0] OpcOpImm = 7'h13;
  localparam logic [6:0] OpcOp    = 7'h33;
  localparam logic [6:0] OpcLui   = 7'h37;
  localparam logic [6:0] OpcAuipc = 7'h17;

  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_operand_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic        w_illegal;
  logic        w_is_op;
  logic        w_accept;
  logic        w_unused_rs1_field;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];
  assign w_imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_u  = {inst_i[31:12], 12'h000};
  assign w_is_op  = (w_opcode == OpcOp);
  // Register numbers are resolved upstream; only the operand values matter here.
  assign w_unused_rs1_field = ^inst_i[19:15];

  // Decode and execute the issued instruction.
  always_comb begin
    w_result    = '0;
    w_illegal   = 1'b0;
    w_operand_b = w_is_op ? rs2_value_i : w_imm_i;
    w_shamt     = w_operand_b[4:0];
    case (w_opcode)
      OpcOpImm, OpcOp: begin
        if (w_is_op) begin
          // funct7 0x20 is only meaningful for SUB and SRA.
          if (!((w_funct7 == 7'h00) ||
                ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))))) begin
            w_illegal = 1'b1;
          end
        end else begin
          // Shift-immediates reuse the upper immediate bits as funct7.
          if (((w_funct3 == 3'b001) && (w_funct7 != 7'h00)) ||
              ((w_funct3 == 3'b101) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20))) begin
            w_illegal = 1'b1;
          end
        end
        case (w_funct3)
          3'b000:  w_result = (w_is_op && w_funct7[5]) ? rs1_value_i - w_operand_b
                                                       : rs1_value_i + w_operand_b;
          3'b001:  w_result = rs1_value_i << w_shamt;
          3'b010:  w_result = {31'b0, ($signed(rs1_value_i) < $signed(w_operand_b))};
          3'b011:  w_result = {31'b0, (rs1_value_i < w_operand_b)};
          3'b100:  w_result = rs1_value_i ^ w_operand_b;
          3'b101:  w_result = w_funct7[5] ? $unsigned($signed(rs1_value_i) >>> w_shamt)
                                          : rs1_value_i >> w_shamt;
          3'b110:  w_result = rs1_value_i | w_operand_b;
          default: w_result = rs1_value_i & w_operand_b;
        endcase
      end
      OpcLui:   w_result = w_imm_u;
      OpcAuipc: w_result = pc_i + w_imm_u;
      default:  w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_result = '0;
    end
  end

  logic [STAGES-1:0] r_valid;
  logic [31:0]       r_value   [STAGES];
  logic [4:0]        r_rd      [STAGES];
  logic [TAG_W-1:0]  r_tag     [STAGES];
  logic              r_illegal [STAGES];
  logic [STAGES-1:0] w_open;

  // A stage can take new contents unless it and every stage ahead of it is
  // full while writeback is stalled; written flat to avoid a comb chain.
  always_comb begin : open_calc
    logic w_all_full;
    w_all_full = 1'b1;
    w_open     = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_all_full = w_all_full & r_valid[k];
      w_open[k]  = wb_ready_i | ~w_all_full;
    end
  end

  assign arith_ready_o = w_open[0];
  assign w_accept      = arith_request_i & arith_ready_o & ~flush_i;

  // Pipeline state: reset beats flush, flush beats accept and advance.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_value[k]   <= '0;
        r_rd[k]      <= '0;
        r_tag[k]     <= '0;
        r_illegal[k] <= 1'b0;
      end
    end else begin
      if (w_open[0]) begin
        r_valid[0] <= w_accept;
        if (w_accept) begin
          r_value[0]   <= w_result;
          r_rd[0]      <= inst_i[11:7];
          r_tag[0]     <= tag_i;
          r_illegal[0] <= w_illegal;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_open[k]) begin
          r_valid[k] <= r_valid[k-1];
          // Payload only moves with a valid entry so bubbles leave it untouched.
          if (r_valid[k-1]) begin
            r_value[k]   <= r_value[k-1];
            r_rd[k]      <= r_rd[k-1];
            r_tag[k]     <= r_tag[k-1];
            r_illegal[k] <= r_illegal[k-1];
          end
        end
      end
      if (flush_i) begin
        r_valid <= '0;
      end
    end
  end

  assign wb_valid_o        = r_valid[STAGES-1];
  assign writeback_value_o = r_value[STAGES-1];
  assign wb_rd_o           = r_rd[STAGES-1];
  assign wb_tag_o          = r_tag[STAGES-1];
  assign wb_illegal_o      = r_illegal[STAGES-1];

endmodule

// File: tb/tb_arith_pipe.sv
// Scoreboard bench for arith_pipe: three instances (STAGES = 1, 2, 4) share
// operand inputs; each has its own request line and expected-result queue.
module tb_arith_pipe;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  rd;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wb_ready;
  logic [31:0] pcv, inst, rs1, rs2;
  logic [4:0]  tag;
  logic        req   [3];
  logic        rdy   [3];
  logic        wv    [3];
  logic [31:0] wval  [3];
  logic [4:0]  wrd   [3];
  logic [4:0]  wtag  [3];
  logic        will  [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  arith_pipe #(.STAGES(1), .TAG_W(5)) u_s1 (
    .clk_i(clk), .reset_i(rst), .arith_request_i(req[0]), .arith_ready_o(rdy[0]),
    .pc_i(pcv), .inst_i(inst), .rs1_value_i(rs1), .rs2_value_i(rs2), .tag_i(tag),
    .flush_i(flush), .wb_valid_o(wv[0]), .wb_ready_i(wb_ready),
    .writeback_value_o(wval[0]), .wb_rd_o(wrd[0]), .wb_tag_o(wtag[0]),
    .wb_illegal_o(will[0])
  );

  arith_pipe #(.STAGES(2), .TAG_W(5)) u_s2 (
    .clk_i(clk), .reset_i(rst), .arith_request_i(req[1]), .arith_ready_o(rdy[1]),
    .pc_i(pcv), .inst_i(inst), .rs1_value_i(rs1), .rs2_value_i(rs2), .tag_i(tag),
    .flush_i(flush), .wb_valid_o(wv[1]), .wb_ready_i(wb_ready),
    .writeback_value_o(wval[1]), .wb_rd_o(wrd[1]), .wb_tag_o(wtag[1]),
    .wb_illegal_o(will[1])
  );

  arith_pipe #(.STAGES(4), .TAG_W(5)) u_s4 (
    .clk_i(clk), .reset_i(rst), .arith_request_i(req[2]), .arith_ready_o(rdy[2]),
    .pc_i(pcv), .inst_i(inst), .rs1_value_i(rs1), .rs2_value_i(rs2), .tag_i(tag),
    .flush_i(flush), .wb_valid_o(wv[2]), .wb_ready_i(wb_ready),
    .writeback_value_o(wval[2]), .wb_rd_o(wrd[2]), .wb_tag_o(wtag[2]),
    .wb_illegal_o(will[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int d, output exp_t e);
    bit ok;
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  // Monitor: every writeback handshake must match the oldest expected entry.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (wv[d] && wb_ready) begin
        exp_t got;
        exp_t want;
        got = {wval[d], wrd[d], wtag[d], will[d]};
        if (!pop(d, want)) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected result dut%0d: got %h want none", d, got);
        end else begin
          check($sformatf("result dut%0d", d), 64'(got), 64'(want));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int d, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [4:0] tg,
                       input logic [31:0] ev, input logic eill, output int stalls);
    exp_t e;
    int   waits;
    bit   done;
    waits = 0;
    done  = 1'b0;
    inst  = ins;
    rs1   = a;
    rs2   = b;
    pcv   = pc;
    tag   = tg;
    req[d] = 1'b1;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (rdy[d] && !flush) begin
        e = {ev, ins[11:7], tg, eill};
        push(d, e);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    req[d] = 1'b0;
    stalls = waits;
    check("issue accepted", 64'(done), 64'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latency(input int d, input int s);
    int st;
    issue(d, 32'h00518093, 32'd2, 32'd0, 32'd0, 5'd3, 32'h7, 1'b0, st);
    for (int i = 1; i < s; i++) begin
      @(negedge clk);
      check($sformatf("latency early s%0d", s), 64'(wv[d]), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check($sformatf("latency valid s%0d", s), 64'(wv[d]), 64'd1);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    pcv = '0; inst = '0; rs1 = '0; rs2 = '0; tag = '0;
    for (int d = 0; d < 3; d++) req[d] = 1'b0;
    tick(2);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset outputs dut%0d", d),
            64'({wv[d], wval[d], wrd[d], wtag[d], will[d]}), 64'd0);
      check($sformatf("reset ready dut%0d", d), 64'(rdy[d]), 64'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic latency on STAGES=2.
    latency(1, 2);
    tick(2);

    // Back-to-back stream; every issue must be accepted without a stall.
    issue(1, 32'h00209113, 32'h5,        32'h0,        32'h0,   5'd4,  32'h14,       1'b0, st);
    check("stream stall slli", 64'(st), 64'd0);
    issue(1, 32'h40208133, 32'h10,       32'h5,        32'h0,   5'd5,  32'hB,        1'b0, st);
    check("stream stall sub", 64'(st), 64'd0);
    issue(1, 32'h123450B7, 32'h0,        32'h0,        32'h0,   5'd6,  32'h12345000, 1'b0, st);
    issue(1, 32'h00001097, 32'h0,        32'h0,        32'h100, 5'd7,  32'h1100,     1'b0, st);
    issue(1, 32'h00000000, 32'h1234,     32'h1,        32'h0,   5'd8,  32'h0,        1'b1, st);
    issue(1, 32'h4020D093, 32'h80000000, 32'h0,        32'h0,   5'd9,  32'hE0000000, 1'b0, st);
    issue(1, 32'hFFF00093, 32'h0,        32'h0,        32'h0,   5'd10, 32'hFFFFFFFF, 1'b0, st);
    issue(1, 32'h4020C133, 32'h1,        32'h2,        32'h0,   5'd11, 32'h0,        1'b1, st);
    issue(1, 32'h0020B133, 32'h1,        32'hFFFFFFFF, 32'h0,   5'd12, 32'h1,        1'b0, st);
    issue(1, 32'h0020A133, 32'hFFFFFFFF, 32'h1,        32'h0,   5'd13, 32'h1,        1'b0, st);
    issue(1, 32'h0020D133, 32'h80000000, 32'h21,       32'h0,   5'd14, 32'h40000000, 1'b0, st);
    check("stream stall srl", 64'(st), 64'd0);
    tick(4);

    // Backpressure: two accepts fill the pipe, then ready drops and output holds.
    wb_ready = 1'b0;
    issue(1, 32'h00518093, 32'd2, 32'd0, 32'd0, 5'd15, 32'h7,  1'b0, st);
    issue(1, 32'h00209113, 32'd5, 32'd0, 32'd0, 5'd16, 32'h14, 1'b0, st);
    @(negedge clk);
    check("bp ready low", 64'(rdy[1]), 64'd0);
    check("bp valid", 64'(wv[1]), 64'd1);
    tick(1);
    @(negedge clk);
    check("bp ready still low", 64'(rdy[1]), 64'd0);
    check("bp hold value", 64'({wval[1], wtag[1]}), 64'({32'h7, 5'd15}));
    tick(1);
    wb_ready = 1'b1;
    issue(1, 32'h40208133, 32'h10, 32'h5, 32'h0, 5'd17, 32'hB, 1'b0, st);
    check("bp accept with drain", 64'(st), 64'd0);
    issue(1, 32'h123450B7, 32'h0, 32'h0, 32'h0, 5'd18, 32'h12345000, 1'b0, st);
    tick(4);

    // Flush with two in flight plus a concurrent issue.
    wb_ready = 1'b0;
    issue(1, 32'h00518093, 32'd2, 32'd0, 32'd0, 5'd19, 32'h7,  1'b0, st);
    issue(1, 32'h00209113, 32'd5, 32'd0, 32'd0, 5'd20, 32'h14, 1'b0, st);
    inst = 32'h00518093; rs1 = 32'd9; tag = 5'd21;
    req[1] = 1'b1;
    flush  = 1'b1;
    tick(1);
    flush  = 1'b0;
    req[1] = 1'b0;
    q1.delete();
    @(negedge clk);
    check("flush valid", 64'(wv[1]), 64'd0);
    check("flush ready", 64'(rdy[1]), 64'd1);
    tick(1);
    wb_ready = 1'b1;
    tick(5);

    // Reset mid-stream with writeback stalled.
    wb_ready = 1'b0;
    issue(1, 32'h40208133, 32'h10, 32'h5, 32'h0, 5'd22, 32'hB,  1'b0, st);
    issue(1, 32'h00209113, 32'd5,  32'd0, 32'd0, 5'd23, 32'h14, 1'b0, st);
    rst = 1'b1;
    tick(1);
    q1.delete();
    @(negedge clk);
    check("midreset outputs",
          64'({wv[1], wval[1], wrd[1], wtag[1], will[1]}), 64'd0);
    check("midreset ready", 64'(rdy[1]), 64'd1);
    tick(1);
    rst = 1'b0;
    wb_ready = 1'b1;
    tick(5);

    // Latency on the other depths.
    latency(0, 1);
    tick(2);
    latency(2, 4);
    tick(6);

    check("sb empty s1", 64'(q0.size()), 64'd0);
    check("sb empty s2", 64'(q1.size()), 64'd0);
    check("sb empty s4", 64'(q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
